// File: rtl/segment_collision_engine.sv
// Line-segment collision scanner: holds up to N_LINES obstacle segments and checks each
// streamed query against them through a 2-stage orientation pipeline, reporting the first hit.
module segment_collision_engine #(
    parameter int W       = 8,
    parameter int N_LINES = 16,
    parameter int ID_W    = (N_LINES > 1) ? $clog2(N_LINES) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_val,
    output logic            in_rdy,
    input  logic            in_load,
    input  logic            clear,
    input  logic [W-1:0]    x1,
    input  logic [W-1:0]    y1,
    input  logic [W-1:0]    x2,
    input  logic [W-1:0]    y2,
    output logic            out_val,
    output logic            out_hit,
    output logic [ID_W-1:0] lineID,
    output logic [ID_W:0]   count,
    output logic            full
);

    localparam logic [0:0]    IDLE   = 1'b0;
    localparam logic [0:0]    SCAN   = 1'b1;
    localparam logic [ID_W:0] ZERO_C = (ID_W+1)'(0);
    localparam logic [ID_W:0] ONE_C  = (ID_W+1)'(1);
    localparam logic [ID_W:0] MAX_C  = (ID_W+1)'(N_LINES);

    // Sign of (qy-py)*(rx-qx) - (qx-px)*(ry-qy), computed at full precision.
    function automatic logic [1:0] orient(input logic [W-1:0] px, input logic [W-1:0] py,
                                          input logic [W-1:0] qx, input logic [W-1:0] qy,
                                          input logic [W-1:0] rx, input logic [W-1:0] ry);
        logic [W:0]     dy1;
        logic [W:0]     dx1;
        logic [W:0]     dx2;
        logic [W:0]     dy2;
        logic [2*W+1:0] m1;
        logic [2*W+1:0] m2;
        logic [2*W+2:0] v;
        dy1 = {1'b0, qy} - {1'b0, py};
        dx2 = {1'b0, rx} - {1'b0, qx};
        dx1 = {1'b0, qx} - {1'b0, px};
        dy2 = {1'b0, ry} - {1'b0, qy};
        m1  = {{(W+1){dy1[W]}}, dy1} * {{(W+1){dx2[W]}}, dx2};
        m2  = {{(W+1){dx1[W]}}, dx1} * {{(W+1){dy2[W]}}, dy2};
        v   = {m1[2*W+1], m1} - {m2[2*W+1], m2};
        if (v == {(2*W+3){1'b0}}) begin
            return 2'b00;
        end else if (v[2*W+2]) begin
            return 2'b10;
        end else begin
            return 2'b01;
        end
    endfunction

    function automatic logic [W-1:0] min_w(input logic [W-1:0] a, input logic [W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [W-1:0] max_w(input logic [W-1:0] a, input logic [W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic in_box(input logic [W-1:0] px,  input logic [W-1:0] py,
                                    input logic [W-1:0] lox, input logic [W-1:0] hix,
                                    input logic [W-1:0] loy, input logic [W-1:0] hiy);
        return (px >= lox) && (px <= hix) && (py >= loy) && (py <= hiy);
    endfunction

    logic [0:0]      state_r;
    logic            in_rdy_r;
    logic            out_val_r;
    logic            out_hit_r;
    logic [ID_W-1:0] line_id_r;
    logic [ID_W:0]   count_r;
    logic            full_r;
    logic [ID_W:0]   idx_r;

    logic [W-1:0] tbl_x1_r [N_LINES];
    logic [W-1:0] tbl_y1_r [N_LINES];
    logic [W-1:0] tbl_x2_r [N_LINES];
    logic [W-1:0] tbl_y2_r [N_LINES];

    logic [W-1:0] qx1_r, qy1_r, qx2_r, qy2_r;
    logic [W-1:0] qminx_r, qmaxx_r, qminy_r, qmaxy_r;

    logic            s1_val_r;
    logic            s1_last_r;
    logic [ID_W-1:0] s1_id_r;
    logic [1:0]      s1_o1_r, s1_o2_r, s1_o3_r, s1_o4_r;
    logic [W-1:0]    s1_px_r, s1_py_r, s1_qx_r, s1_qy_r;
    logic [W-1:0]    s1_minx_r, s1_maxx_r, s1_miny_r, s1_maxy_r;

    logic [W-1:0] rd_x1_s, rd_y1_s, rd_x2_s, rd_y2_s;
    logic         scan_live_s;
    logic         issue_s;
    logic         hit_s;
    logic         found_s;
    logic         miss_s;

    // Table read port and stage-2 decision for the entry held in stage 1.
    always_comb begin
        rd_x1_s     = tbl_x1_r[idx_r[ID_W-1:0]];
        rd_y1_s     = tbl_y1_r[idx_r[ID_W-1:0]];
        rd_x2_s     = tbl_x2_r[idx_r[ID_W-1:0]];
        rd_y2_s     = tbl_y2_r[idx_r[ID_W-1:0]];
        hit_s       = ((s1_o1_r != s1_o2_r) && (s1_o3_r != s1_o4_r))
                   || ((s1_o1_r == 2'b00) && in_box(qx1_r, qy1_r, s1_minx_r, s1_maxx_r, s1_miny_r, s1_maxy_r))
                   || ((s1_o2_r == 2'b00) && in_box(qx2_r, qy2_r, s1_minx_r, s1_maxx_r, s1_miny_r, s1_maxy_r))
                   || ((s1_o3_r == 2'b00) && in_box(s1_px_r, s1_py_r, qminx_r, qmaxx_r, qminy_r, qmaxy_r))
                   || ((s1_o4_r == 2'b00) && in_box(s1_qx_r, s1_qy_r, qminx_r, qmaxx_r, qminy_r, qmaxy_r));
        // Once out_val is raised the scan is finished; the cycle after only returns to IDLE.
        scan_live_s = (state_r == SCAN) && !out_val_r;
        issue_s     = scan_live_s && (idx_r < count_r);
        found_s     = scan_live_s && s1_val_r && hit_s;
        miss_s      = scan_live_s && ((count_r == ZERO_C) || (s1_val_r && s1_last_r && !hit_s));
    end

    // Control FSM, occupancy counter, pipeline valid and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            in_rdy_r  <= 1'b1;
            out_val_r <= 1'b0;
            out_hit_r <= 1'b0;
            line_id_r <= {ID_W{1'b0}};
            count_r   <= ZERO_C;
            full_r    <= 1'b0;
            idx_r     <= ZERO_C;
            s1_val_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    out_val_r <= 1'b0;
                    s1_val_r  <= 1'b0;
                    if (clear) begin
                        count_r <= ZERO_C;
                        full_r  <= 1'b0;
                    end else if (in_val && in_load) begin
                        if (!full_r) begin
                            count_r <= count_r + ONE_C;
                            full_r  <= ((count_r + ONE_C) == MAX_C);
                        end
                    end else if (in_val) begin
                        state_r  <= SCAN;
                        in_rdy_r <= 1'b0;
                        idx_r    <= ZERO_C;
                    end
                end
                SCAN: begin
                    if (out_val_r) begin
                        out_val_r <= 1'b0;
                        state_r   <= IDLE;
                        in_rdy_r  <= 1'b1;
                        s1_val_r  <= 1'b0;
                    end else begin
                        s1_val_r <= issue_s && !found_s && !miss_s;
                        if (issue_s) begin
                            idx_r <= idx_r + ONE_C;
                        end
                        if (found_s) begin
                            out_val_r <= 1'b1;
                            out_hit_r <= 1'b1;
                            line_id_r <= s1_id_r;
                        end else if (miss_s) begin
                            out_val_r <= 1'b1;
                            out_hit_r <= 1'b0;
                            line_id_r <= {ID_W{1'b0}};
                        end
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    in_rdy_r  <= 1'b1;
                    out_val_r <= 1'b0;
                    s1_val_r  <= 1'b0;
                end
            endcase
        end
    end

    // Obstacle table writes, query capture and stage-1 orientation datapath.
    always_ff @(posedge clk) begin
        if ((state_r == IDLE) && !clear && in_val && in_load && !full_r) begin
            tbl_x1_r[count_r[ID_W-1:0]] <= x1;
            tbl_y1_r[count_r[ID_W-1:0]] <= y1;
            tbl_x2_r[count_r[ID_W-1:0]] <= x2;
            tbl_y2_r[count_r[ID_W-1:0]] <= y2;
        end
        if ((state_r == IDLE) && !clear && in_val && !in_load) begin
            qx1_r   <= x1;
            qy1_r   <= y1;
            qx2_r   <= x2;
            qy2_r   <= y2;
            qminx_r <= min_w(x1, x2);
            qmaxx_r <= max_w(x1, x2);
            qminy_r <= min_w(y1, y2);
            qmaxy_r <= max_w(y1, y2);
        end
        if (issue_s) begin
            s1_last_r <= ((idx_r + ONE_C) == count_r);
            s1_id_r   <= idx_r[ID_W-1:0];
            s1_o1_r   <= orient(rd_x1_s, rd_y1_s, rd_x2_s, rd_y2_s, qx1_r, qy1_r);
            s1_o2_r   <= orient(rd_x1_s, rd_y1_s, rd_x2_s, rd_y2_s, qx2_r, qy2_r);
            s1_o3_r   <= orient(qx1_r, qy1_r, qx2_r, qy2_r, rd_x1_s, rd_y1_s);
            s1_o4_r   <= orient(qx1_r, qy1_r, qx2_r, qy2_r, rd_x2_s, rd_y2_s);
            s1_px_r   <= rd_x1_s;
            s1_py_r   <= rd_y1_s;
            s1_qx_r   <= rd_x2_s;
            s1_qy_r   <= rd_y2_s;
            s1_minx_r <= min_w(rd_x1_s, rd_x2_s);
            s1_maxx_r <= max_w(rd_x1_s, rd_x2_s);
            s1_miny_r <= min_w(rd_y1_s, rd_y2_s);
            s1_maxy_r <= max_w(rd_y1_s, rd_y2_s);
        end
    end

    assign in_rdy  = in_rdy_r;
    assign out_val = out_val_r;
    assign out_hit = out_hit_r;
    assign lineID  = line_id_r;
    assign count   = count_r;
    assign full    = full_r;

endmodule
